// File: rtl/wb_burst_master.sv
// Wishbone B4 classic-burst master moving LEN words between a local stream and a word-addressed slave.
// One FIFO buffers write data ahead of a burst (or read data behind it), so STB never stalls mid-burst.
module wb_burst_master #(
  parameter int Dw        = 32,
  parameter int Aw        = 10,
  parameter int LENw      = 10,
  parameter int MAX_BURST = 16,
  parameter int FIFO_Aw   = 4,
  parameter int SELw      = Dw / 8,
  parameter int CTIw      = 3,
  parameter int BTEw      = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [Aw-1:0]   cmd_addr,
  input  logic [LENw-1:0] cmd_len,
  input  logic [BTEw-1:0] cmd_bte,
  input  logic [Dw-1:0]   wr_data,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic [Dw-1:0]   rd_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic            done,
  output logic            done_err,
  output logic [Aw-1:0]   m_adr_o,
  output logic [Dw-1:0]   m_dat_o,
  output logic [SELw-1:0] m_sel_o,
  output logic [CTIw-1:0] m_cti_o,
  output logic [BTEw-1:0] m_bte_o,
  output logic            m_stb_o,
  output logic            m_cyc_o,
  output logic            m_we_o,
  input  logic [Dw-1:0]   m_dat_i,
  input  logic            m_ack_i,
  input  logic            m_err_i,
  input  logic            m_rty_i
);
  localparam int DEPTH = 1 << FIFO_Aw;
  localparam logic [FIFO_Aw:0] DEPTH_C = (FIFO_Aw + 1)'(DEPTH);
  localparam logic [FIFO_Aw:0] CNT_ONE = (FIFO_Aw + 1)'(1);

  typedef enum logic [1:0] {IDLE, ARM, BUS, DONE} state_t;
  state_t state, state_nxt;

  logic               we_r, err_r, single_r;
  logic [BTEw-1:0]    bte_r;
  logic [Aw-1:0]      adr, adr_nxt, wrap_mask;
  logic [LENw-1:0]    remaining, wr_left, beats, chunk;
  logic [Dw-1:0]      mem [DEPTH];
  logic [FIFO_Aw-1:0] wptr, rptr;
  logic [FIFO_Aw:0]   count;
  logic [31:0]        count_w, free_w, chunk_w;
  logic               push, pop, flush, bus_ack, arm_ok, in_bus;
  logic [Dw-1:0]      push_data;

  assign in_bus  = (state == BUS);
  assign bus_ack = in_bus & m_ack_i & ~m_err_i & ~m_rty_i;
  assign flush   = in_bus & m_err_i & we_r;
  assign chunk   = (remaining > LENw'(MAX_BURST)) ? LENw'(MAX_BURST) : remaining;

  // A burst only starts once the FIFO can source or sink the whole chunk without a wait state.
  assign count_w = 32'(count);
  assign free_w  = 32'(DEPTH_C - count);
  assign chunk_w = 32'(chunk);
  assign arm_ok  = we_r ? (count_w >= chunk_w) : (free_w >= chunk_w);

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = we_r & ((state == ARM) | in_bus) & (count != DEPTH_C) & (wr_left != '0);
  assign rd_valid  = ~we_r & (state != IDLE) & (count != '0);
  assign rd_data   = mem[rptr];
  assign done      = (state == DONE) & (we_r | (count == '0));
  assign done_err  = done & err_r;

  assign m_cyc_o = in_bus;
  assign m_stb_o = in_bus;
  assign m_we_o  = in_bus & we_r;
  assign m_adr_o = adr;
  assign m_sel_o = in_bus ? '1 : '0;
  assign m_bte_o = in_bus ? bte_r : '0;
  assign m_dat_o = (in_bus & we_r) ? mem[rptr] : '0;

  assign push      = we_r ? (wr_valid & wr_ready) : bus_ack;
  assign pop       = we_r ? bus_ack : (rd_valid & rd_ready);
  assign push_data = we_r ? wr_data : m_dat_i;

  always_comb begin
    wrap_mask = '1;
    case (bte_r)
      2'b01:   wrap_mask = Aw'(3);
      2'b10:   wrap_mask = Aw'(7);
      2'b11:   wrap_mask = Aw'(15);
      default: wrap_mask = '1;
    endcase
    adr_nxt = (adr & ~wrap_mask) | ((adr + Aw'(1)) & wrap_mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_cti_o   = '0;
    case (state)
      IDLE: if (cmd_valid) state_nxt = (cmd_len == '0) ? DONE : ARM;
      ARM:  if (arm_ok) state_nxt = BUS;
      BUS: begin
        if (single_r)                m_cti_o = CTIw'(3'b000);
        else if (beats == LENw'(1))  m_cti_o = CTIw'(3'b111);
        else                         m_cti_o = CTIw'(3'b010);
        // Leaving BUS always passes through ARM or DONE, which gives the idle cycle between bursts.
        if (m_err_i)                               state_nxt = DONE;
        else if (m_rty_i)                          state_nxt = ARM;
        else if (m_ack_i && beats == LENw'(1))     state_nxt = (remaining == LENw'(1)) ? DONE : ARM;
      end
      DONE: if (we_r || count == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_r      <= 1'b0;
      err_r     <= 1'b0;
      single_r  <= 1'b0;
      bte_r     <= '0;
      adr       <= '0;
      remaining <= '0;
      wr_left   <= '0;
      beats     <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        we_r      <= cmd_we;
        bte_r     <= cmd_bte;
        adr       <= cmd_addr;
        remaining <= cmd_len;
        wr_left   <= cmd_we ? cmd_len : '0;
        err_r     <= (cmd_len == '0);
      end
      if (state == ARM && arm_ok) begin
        beats    <= chunk;
        single_r <= (chunk == LENw'(1));
      end
      if (in_bus && m_err_i) err_r <= 1'b1;
      if (bus_ack) begin
        adr       <= adr_nxt;
        remaining <= remaining - LENw'(1);
        beats     <= beats - LENw'(1);
      end
      // wr_left stops the stream from pushing words that belong to the next command.
      if (wr_valid && wr_ready) wr_left <= wr_left - LENw'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + FIFO_Aw'(1);
      if (pop)  rptr <= rptr + FIFO_Aw'(1);
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= push_data;
  end
endmodule
